guess_game_ctrl: RTL and testbench



---
 rtl/guess_game_pkg.sv | 35 +++
 rtl/guess_game_ctrl_lfsr8.sv | 22 ++
 rtl/guess_game_ctrl.sv | 138 +++++++++++++
 tb/tb_guess_game_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared constants and helpers for the guess-game sequencer: state codes, hint codes,
// LFSR tap mask and BCD utilities.
package guess_game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WIN   = 3'd3;
  localparam logic [2:0] ST_LOSE  = 3'd4;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_EQ   = 2'b11;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] to_bcd(input int unsigned val);
    return {4'((val / 10) % 10), 4'(val % 10)};
  endfunction

  // Folds 10..15 onto 4..9 so every nibble maps to a decimal digit.
  function automatic logic [3:0] lfsr_digit(input logic [3:0] nib);
    return (nib > 4'd9) ? (nib - 4'd6) : nib;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] val);
    if (val[3:0] == 4'd9) begin
      return {val[7:4] + 4'd1, 4'd0};
    end
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/guess_game_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a zero seed is replaced by 8'h01 to avoid lock-up.
module lfsr8
  import guess_game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [7:0] q
);

  localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= INIT;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-game sequencer: owns round state, BCD try count and display values.
// Optional feature: define GUESS_REVEAL_EN to show the secret on entry to LOSE.
module guess_game_ctrl
  import guess_game_pkg::*;
#(
  parameter int unsigned MAX_TRIES   = 9,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] disp_data,
  output logic [7:0] disp_tries,
  output logic [1:0] hint,
  output logic       busy,
  output logic       game_over
);

  localparam logic [7:0]        MAX_BCD   = to_bcd(MAX_TRIES);
  localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic              start_q;
  logic [3:0]        secret_q, secret_d;
  logic [3:0]        guess_q, guess_d;
  logic [7:0]        tries_q, tries_d;
  logic [3:0]        data_q, data_d;
  logic [1:0]        hint_q, hint_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        lfsr_q;
  logic [7:0]        tries_inc;
  logic              start_edge;
  logic              lfsr_unused;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .q   (lfsr_q)
  );

  // Only the low nibble seeds the secret; the upper bits just keep the sequence long.
  assign lfsr_unused = ^lfsr_q[7:4];

  assign start_edge = start & ~start_q;
  assign tries_inc  = bcd_inc(tries_q);

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    tries_d  = tries_q;
    data_d   = data_q;
    hint_d   = hint_q;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d  = ST_PLAY;
          secret_d = lfsr_digit(lfsr_q[3:0]);
          tries_d  = 8'h00;
          hint_d   = HINT_NONE;
          data_d   = 4'd0;
        end
      end
      ST_PLAY: begin
        if (key_valid && (key_code <= 4'd9)) begin
          guess_d = key_code;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        tries_d = tries_inc;
        data_d  = guess_q;
        hold_d  = '0;
        if (guess_q == secret_q) begin
          hint_d  = HINT_EQ;
          state_d = ST_WIN;
        end else begin
          hint_d = (guess_q < secret_q) ? HINT_LOW : HINT_HIGH;
          if (tries_inc == MAX_BCD) begin
            state_d = ST_LOSE;
`ifdef GUESS_REVEAL_EN
            data_d  = secret_q;
`else
            data_d  = guess_q;
`endif
          end else begin
            state_d = ST_PLAY;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        // Display registers are left alone so the result stays visible in IDLE.
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      secret_q <= 4'd0;
      guess_q  <= 4'd0;
      tries_q  <= 8'h00;
      data_q   <= 4'd0;
      hint_q   <= HINT_NONE;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      tries_q  <= tries_d;
      data_q   <= data_d;
      hint_q   <= hint_d;
      hold_q   <= hold_d;
    end
  end

  assign disp_data  = data_q;
  assign disp_tries = tries_q;
  assign hint       = hint_q;
  assign busy       = (state_q == ST_PLAY) || (state_q == ST_CHECK);
  assign game_over  = (state_q == ST_WIN) || (state_q == ST_LOSE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: two instances (MAX_TRIES 3 and 12, HOLD_CYCLES 4) on shared
// stimulus, checked every cycle against an integer reference model plus directed sequences.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;

  logic [3:0] data_a, data_b;
  logic [7:0] tries_a, tries_b;
  logic [1:0] hint_a, hint_b;
  logic       busy_a, busy_b, go_a, go_b;

  int checks = 0;
  int errors = 0;

`ifdef GUESS_REVEAL_EN
  localparam bit REVEAL = 1'b1;
`else
  localparam bit REVEAL = 1'b0;
`endif

  always #5 clk = ~clk;

  guess_game_ctrl #(.MAX_TRIES(3), .HOLD_CYCLES(4), .LFSR_SEED(8'hA5)) u_dut_a (
    .CLK(clk), .RST(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
    .disp_data(data_a), .disp_tries(tries_a), .hint(hint_a), .busy(busy_a), .game_over(go_a)
  );

  guess_game_ctrl #(.MAX_TRIES(12), .HOLD_CYCLES(4), .LFSR_SEED(8'hA5)) u_dut_b (
    .CLK(clk), .RST(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
    .disp_data(data_b), .disp_tries(tries_b), .hint(hint_b), .busy(busy_b), .game_over(go_b)
  );

  // Reference model: game rules over plain integers.
  typedef enum int {M_IDLE, M_PLAY, M_CHECK, M_WIN, M_LOSE} mstate_e;
  localparam int HOLD = 4;
  int      max_t[2]    = '{3, 12};
  mstate_e m_st[2]     = '{M_IDLE, M_IDLE};
  int      m_secret[2] = '{0, 0};
  int      m_guess[2]  = '{0, 0};
  int      m_tries[2]  = '{0, 0};
  int      m_hint[2]   = '{0, 0};
  int      m_data[2]   = '{0, 0};
  int      m_hold[2]   = '{0, 0};
  int      m_lfsr      = 'hA5;
  bit      m_start_q   = 1'b0;

  typedef struct {
    logic [3:0] code;
    logic [1:0] hint;
    logic [7:0] tries;
    logic       over;
  } vec_t;

  function automatic int cand(input int l);
    int c = l % 16;
    return (c > 9) ? c - 6 : c;
  endfunction

  function automatic logic [7:0] bcd(input int t);
    return 8'((t / 10) * 16 + (t % 10));
  endfunction

  task automatic model_update();
    int  c;
    bit  sedge;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = M_IDLE; m_tries[i] = 0; m_hint[i] = 0; m_data[i] = 0;
      end
      m_lfsr = 'hA5;
      m_start_q = 1'b0;
    end else begin
      c = cand(m_lfsr);
      sedge = start && !m_start_q;
      for (int i = 0; i < 2; i++) begin
        case (m_st[i])
          M_IDLE: if (sedge) begin
            m_st[i] = M_PLAY; m_secret[i] = c; m_tries[i] = 0; m_hint[i] = 0; m_data[i] = 0;
          end
          M_PLAY: if (key_valid && key_code <= 9) begin
            m_guess[i] = int'(key_code); m_st[i] = M_CHECK;
          end
          M_CHECK: begin
            m_tries[i]++;
            m_data[i] = m_guess[i];
            m_hold[i] = 0;
            m_hint[i] = (m_guess[i] < m_secret[i]) ? 1 : (m_guess[i] > m_secret[i]) ? 2 : 3;
            if (m_hint[i] == 3) m_st[i] = M_WIN;
            else if (m_tries[i] == max_t[i]) begin
              m_st[i] = M_LOSE;
              if (REVEAL) m_data[i] = m_secret[i];
            end else m_st[i] = M_PLAY;
          end
          default: begin
            m_hold[i]++;
            if (m_hold[i] == HOLD) m_st[i] = M_IDLE;
          end
        endcase
      end
      m_start_q = start;
      m_lfsr = ((m_lfsr * 2) % 256) +
               (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m_data_a", 8'(data_a), 8'(m_data[0]));
    chk("m_tries_a", tries_a, bcd(m_tries[0]));
    chk("m_hint_a", 8'(hint_a), 8'(m_hint[0]));
    chk("m_busy_a", 8'(busy_a), 8'(m_st[0] == M_PLAY || m_st[0] == M_CHECK));
    chk("m_go_a", 8'(go_a), 8'(m_st[0] == M_WIN || m_st[0] == M_LOSE));
    chk("m_data_b", 8'(data_b), 8'(m_data[1]));
    chk("m_tries_b", tries_b, bcd(m_tries[1]));
    chk("m_hint_b", 8'(hint_b), 8'(m_hint[1]));
    chk("m_busy_b", 8'(busy_b), 8'(m_st[1] == M_PLAY || m_st[1] == M_CHECK));
    chk("m_go_b", 8'(go_b), 8'(m_st[1] == M_WIN || m_st[1] == M_LOSE));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic guess(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    cycle();
    key_valid = 1'b0;
    cycle();
  endtask

  // Start a round timed so that the drawn secret equals target.
  task automatic start_with(input int target);
    int n = 0;
    while (cand(m_lfsr) != target && n < 600) begin
      cycle();
      n++;
    end
    chk("secret_wait", 8'(n < 600), 8'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
  endtask

  initial begin
    vec_t       tbl[3];
    int         hold_len;
    logic [3:0] wg;
    logic [1:0] prev_hint;

    tbl[0] = '{4'd2, 2'b01, 8'h01, 1'b0};
    tbl[1] = '{4'd7, 2'b10, 8'h02, 1'b0};
    tbl[2] = '{4'd5, 2'b11, 8'h03, 1'b1};

    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_data", 8'(data_a), 8'h00);
    chk("rst_tries", tries_a, 8'h00);
    chk("rst_busy", 8'(busy_b), 8'h00);
    rst = 1'b0;
    cycle();

    // Secret 5: low, high, correct; each response two cycles after the strobe.
    start_with(5);
    prev_hint = 2'b00;
    for (int k = 0; k < 3; k++) begin
      key_valid = 1'b1;
      key_code  = tbl[k].code;
      cycle();
      key_valid = 1'b0;
      chk("n1_busy_a", 8'(busy_a), 8'h01);
      chk("n1_hint_a", 8'(hint_a), 8'(prev_hint));
      cycle();
      chk("tbl_hint_a", 8'(hint_a), 8'(tbl[k].hint));
      chk("tbl_tries_a", tries_a, tbl[k].tries);
      chk("tbl_go_a", 8'(go_a), 8'(tbl[k].over));
      chk("tbl_hint_b", 8'(hint_b), 8'(tbl[k].hint));
      prev_hint = tbl[k].hint;
    end

    // Hold of 4 cycles; a start pulse during the hold is ignored.
    hold_len = 0;
    for (int k = 0; k < 10; k++) begin
      if (go_a) hold_len++;
      start = (k == 1);
      cycle();
    end
    chk("hold_len", 8'(hold_len), 8'd4);
    chk("kept_hint", 8'(hint_a), 8'h03);
    chk("kept_data", 8'(data_a), 8'h05);
    chk("kept_tries", tries_a, 8'h03);
    chk("idle_busy", 8'(busy_a), 8'h00);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_busy", 8'(busy_a), 8'h01);
    chk("restart_tries", tries_a, 8'h00);
    chk("restart_hint", 8'(hint_a), 8'h00);

    // Reset in the middle of a round with three tries counted.
    wg = (m_secret[1] == 0) ? 4'd9 : 4'd0;
    for (int k = 0; k < 3; k++) guess(wg);
    chk("pre_rst_tries_b", tries_b, 8'h03);
    chk("pre_rst_busy_b", 8'(busy_b), 8'h01);
    rst = 1'b1;
    cycle();
    chk("mid_rst_busy_b", 8'(busy_b), 8'h00);
    chk("mid_rst_tries_b", tries_b, 8'h00);
    chk("mid_rst_hint_b", 8'(hint_b), 8'h00);
    chk("mid_rst_data_b", 8'(data_b), 8'h00);
    chk("mid_rst_go_a", 8'(go_a), 8'h00);
    rst = 1'b0;
    cycle();

    // Secret 4: instance A loses on the third wrong guess.
    start_with(4);
    guess(4'd0);
    guess(4'd1);
    guess(4'd2);
    chk("lose_go_a", 8'(go_a), 8'h01);
    chk("lose_busy_a", 8'(busy_a), 8'h00);
    chk("lose_data_a", 8'(data_a), REVEAL ? 8'h04 : 8'h02);
    chk("lose_tries_a", tries_a, 8'h03);
    chk("play_tries_b", tries_b, 8'h03);

    // BCD carry on instance B.
    for (int g = 4; g <= 10; g++) begin
      guess(4'd0);
      if (g == 9) chk("tries_b_09", tries_b, 8'h09);
      if (g == 10) chk("tries_b_10", tries_b, 8'h10);
    end

    // Non-digit key and a strobe during CHECK are both dropped.
    key_valid = 1'b1;
    key_code  = 4'hC;
    cycle();
    key_valid = 1'b0;
    cycle();
    chk("keyc_tries_b", tries_b, 8'h10);
    chk("keyc_busy_b", 8'(busy_b), 8'h01);
    key_valid = 1'b1;
    key_code  = 4'd0;
    cycle();
    key_code  = 4'd3;
    cycle();
    key_valid = 1'b0;
    cycle();
    cycle();
    chk("lost_strobe_tries_b", tries_b, 8'h11);
    chk("lost_strobe_busy_b", 8'(busy_b), 8'h01);
    guess(4'd0);
    chk("lose_tries_b", tries_b, 8'h12);
    chk("lose_go_b", 8'(go_b), 8'h01);
    chk("lose_data_b", 8'(data_b), REVEAL ? 8'h04 : 8'h00);

    for (int k = 0; k < 6; k++) cycle();

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) start = ~start;
      key_valid = ($urandom_range(0, 2) == 0);
      key_code  = 4'($urandom_range(0, 11));
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
